mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: MEM_LATENCY, 2, cycles a load/store occupies the stage (legal 1..15).
REQ-002 Parameter: ADDR_WIDTH, 8, data-memory word-address width (2^ADDR_WIDTH x 16-bit words).
REQ-003 Port: clk  in  1  single rising-edge clock.
REQ-004 Port: rest  in  1  reset, synchronous, active-high.
REQ-005 Port: Freze  in  1  global pipeline freeze; holds all state.
REQ-006 Port: Controll_In  in  16  control word from EX; bit10 RegWrite, bit4 MemRead, bit3 MemWrite, bits[2:1] WB select.
REQ-007 Port: Adder_In  in  16  PC/branch adder result from EX.
REQ-008 Port: Alu_In  in  16  ALU result from EX; memory address source.
REQ-009 Port: WriteData_In  in  16  store data from EX.
REQ-010 Port: Rd_In  in  16  destination register field from EX (low 4 bits significant).
REQ-011 Port: Controll_Out, Adder_Out, Alu_Out, Memory_Out, Rd_Out  out  16 each  to WB stage inputs Controll_In, Adder_In, Alu_In, Memory_In, Rd_In.
REQ-012 Port: Mem_Stall  out  1  high while a memory access is incomplete; upstream stages hold.

Function
REQ-013 EX2MEM register SHALL capture all five inputs on clk rising edge when Freze=0 and Mem_Stall=0; otherwise hold.
REQ-014 Mem op SHALL be defined as registered Controll bit4 OR bit3; bit4 and bit3 both set SHALL be treated as a store only.
REQ-015 FSM states: IDLE, BUSY. On capturing a mem op with MEM_LATENCY>1: next state BUSY, counter cnt <= MEM_LATENCY-1; otherwise IDLE, cnt <= 0.
REQ-016 In BUSY with Freze=0, cnt SHALL decrement by 1 per cycle; on reaching 0 FSM returns to IDLE.
REQ-017 Mem_Stall SHALL equal (cnt != 0), combinationally from state; MEM_LATENCY=1 never stalls.
REQ-018 Memory address SHALL be registered Alu[ADDR_WIDTH-1:0]; upper bits ignored, no wrap check.
REQ-019 Store SHALL write registered WriteData exactly once, on the cycle with cnt=0, MemWrite=1, Freze=0, rest=0.
REQ-020 Memory_Out SHALL be the combinational read of the addressed word; valid on the cycle with cnt=0.
REQ-021 Adder_Out, Alu_Out, Rd_Out SHALL be registered values passed through unchanged.
REQ-022 Controll_Out SHALL be 0 (bubble) while Mem_Stall=1, else the registered control word.
REQ-023 Freze=1 SHALL hold register, FSM, cnt, and suppress memory write.
REQ-024 Load followed by store to same address: load completes fully before store is captured; no bypass.

Reset
REQ-025 rest=1 at a clock edge SHALL clear EX2MEM register to 0, FSM to IDLE, cnt to 0; rest has priority over Freze.
REQ-026 Reset mid-access SHALL abort it; pending store SHALL NOT write.
REQ-027 Memory array contents SHALL NOT be reset.
REQ-028 During and after reset all outputs SHALL read 0 except Memory_Out (word 0 contents).

Structure
REQ-029 Control-bit indices (RegWrite=10, MemRead=4, MemWrite=3, WBSel=2:1) and FSM state encodings SHALL live in the shared CPU package.
REQ-030 Data memory SHALL be one sub-module, data_memory (sync write, async read, parameter ADDR_WIDTH).
REQ-031 EX2MEM register and FSM SHALL reside in mem_stage.

Verification
REQ-032 Reset: rest=1 two cycles -> all outputs 0 except Memory_Out, Mem_Stall=0.
REQ-033 Store/load, MEM_LATENCY=2: store 0xBEEF at Alu=0x0012 -> Mem_Stall high 1 cycle, Controll_Out=0 that cycle; later load Alu=0x0012 -> Memory_Out=0xBEEF on cnt=0 cycle, Controll_Out passes bit10.
REQ-034 Non-mem op (Controll_In=0x0402, Alu_In=0x1234, Rd_In=0x0005) -> next cycle Alu_Out=0x1234, Rd_Out=0x0005, Controll_Out=0x0402, Mem_Stall=0.
REQ-035 Freze: assert Freze=1 for 3 cycles mid-BUSY, MEM_LATENCY=4 -> cnt frozen, Mem_Stall stays 1, total stall = 3+3 cycles, single write.
REQ-036 Reset mid-store: store 0x5555 to 0x0020 (prior 0x1111), rest=1 while BUSY -> word 0x0020 still 0x1111, FSM IDLE.
REQ-037 Address truncation: store 0xA5A5 at Alu=0x0112, ADDR_WIDTH=8 -> load from Alu=0x0012 returns 0xA5A5.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions for the MEM stage: control-word bit positions and
// the access-sequencer state encoding.
package mem_stage_pkg;

    localparam int CTRL_REGWRITE = 10;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_WBSEL_HI = 2;
    localparam int CTRL_WBSEL_LO = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    // A control word with both MemRead and MemWrite set is still one access (a store).
    function automatic logic is_mem_op(input logic [15:0] ctrl);
        return ctrl[CTRL_MEMREAD] | ctrl[CTRL_MEMWRITE];
    endfunction

    function automatic logic [1:0] wb_sel(input logic [15:0] ctrl);
        return ctrl[CTRL_WBSEL_HI:CTRL_WBSEL_LO];
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX->MEM->WB bus of the MEM stage; slave is the stage, master is its environment.
interface mem_stage_if;

    logic        Freze;
    logic [15:0] Controll_In;
    logic [15:0] Adder_In;
    logic [15:0] Alu_In;
    logic [15:0] WriteData_In;
    logic [15:0] Rd_In;

    logic [15:0] Controll_Out;
    logic [15:0] Adder_Out;
    logic [15:0] Alu_Out;
    logic [15:0] Memory_Out;
    logic [15:0] Rd_Out;
    logic        Mem_Stall;

    modport slave (
        input  Freze, Controll_In, Adder_In, Alu_In, WriteData_In, Rd_In,
        output Controll_Out, Adder_Out, Alu_Out, Memory_Out, Rd_Out, Mem_Stall
    );

    modport master (
        output Freze, Controll_In, Adder_In, Alu_In, WriteData_In, Rd_In,
        input  Controll_Out, Adder_Out, Alu_Out, Memory_Out, Rd_Out, Mem_Stall
    );

endinterface

// File: rtl/mem_stage_data_memory.sv
// 16-bit word data memory: synchronous write, asynchronous read, never reset.
module data_memory #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [15:0]           i_wdata,
    output logic [15:0]           o_rdata
);

    logic [15:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX2MEM register, multi-cycle access sequencer and data memory.
// Loads/stores occupy the stage MEM_LATENCY cycles; the memory is touched on the last one.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        rest,
    mem_stage_if.slave  bus
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);
    localparam bit         MULTI  = (MEM_LATENCY > 1);

    mem_state_t  r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_ctrl;
    logic [15:0] r_adder;
    logic [15:0] r_alu;
    logic [15:0] r_wdata;
    logic [15:0] r_rd;

    logic        w_stall;
    logic        w_we;
    logic [15:0] w_rdata;

    assign w_stall = (r_cnt != 4'd0);
    // The write lands on the final access cycle, which is also the cycle the next op is captured.
    assign w_we    = !w_stall && r_ctrl[CTRL_MEMWRITE] && !bus.Freze && !rest;

    always_ff @(posedge clk) begin
        if (rest) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ctrl  <= '0;
            r_adder <= '0;
            r_alu   <= '0;
            r_wdata <= '0;
            r_rd    <= '0;
        end else if (!bus.Freze) begin
            case (r_state)
                ST_IDLE: begin
                    r_ctrl  <= bus.Controll_In;
                    r_adder <= bus.Adder_In;
                    r_alu   <= bus.Alu_In;
                    r_wdata <= bus.WriteData_In;
                    r_rd    <= bus.Rd_In;
                    if (MULTI && is_mem_op(bus.Controll_In)) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= LAT_M1;
                    end else begin
                        r_cnt   <= 4'd0;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    data_memory #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_alu[ADDR_WIDTH-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign bus.Controll_Out = w_stall ? 16'h0000 : r_ctrl;
    assign bus.Adder_Out    = r_adder;
    assign bus.Alu_Out      = r_alu;
    assign bus.Rd_Out       = r_rd;
    assign bus.Memory_Out   = w_rdata;
    assign bus.Mem_Stall    = w_stall;

endmodule
